snes_pad_emulator: RTL and testbench

//  Device-side end of the serial gamepad link (cont_activate / cont_clk / cont_data).

---
 rtl/snes_pad_emulator.sv | 117 +++++++++++
 tb/tb_snes_pad_emulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_emulator.sv
// Device-side serial gamepad model: latches a button vector on cont_activate and
// shifts it out active-low on cont_data, one bit per synchronized cont_clk rise.
module snes_pad_emulator #(
  parameter int unsigned NUM_BUTTONS = 12,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   cont_activate,
  input  logic                   cont_clk,
  output logic                   cont_data,
  output logic                   frame_done,
  output logic                   frame_aborted,
  output logic [4:0]             bit_index
);

  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] act_sync, pclk_sync;
  logic                   act_s, pclk_s, act_d, pclk_d;
  logic                   act_rise, act_fall, pclk_rise;
  logic [FRAME_BITS-1:0]  shift_reg, shift_next, ld;
  logic [IDX_W-1:0]       idx_next;
  logic                   done_next, abort_next;

  // Pad pins are asynchronous; each goes through its own flop chain plus one edge-detect copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_sync  <= '0;
      pclk_sync <= '0;
      act_d     <= 1'b0;
      pclk_d    <= 1'b0;
    end else begin
      act_sync  <= {act_sync[SYNC_STAGES-2:0], cont_activate};
      pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], cont_clk};
      act_d     <= act_s;
      pclk_d    <= pclk_s;
    end
  end

  assign act_s     = act_sync[SYNC_STAGES-1];
  assign pclk_s    = pclk_sync[SYNC_STAGES-1];
  assign act_rise  = act_s & ~act_d;
  assign act_fall  = ~act_s & act_d;
  assign pclk_rise = pclk_s & ~pclk_d;

  // Padding bits above the buttons read as released.
  always_comb begin
    ld                  = '1;
    ld[NUM_BUTTONS-1:0] = ~buttons;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shift_reg     <= '1;
      cont_data     <= 1'b1;
      bit_index     <= '0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
    end else begin
      state         <= state_next;
      shift_reg     <= shift_next;
      cont_data     <= shift_reg[0];
      bit_index     <= idx_next;
      frame_done    <= done_next;
      frame_aborted <= abort_next;
    end
  end

  // A latch request wins over any shift clock, in every state.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    idx_next   = bit_index;
    done_next  = 1'b0;
    abort_next = 1'b0;
    if (act_rise) begin
      state_next = LATCH;
      shift_next = ld;
      idx_next   = '0;
      abort_next = (state == SHIFT);
    end else begin
      case (state)
        IDLE: begin
        end
        LATCH: begin
          idx_next = '0;
          if (act_s) begin
            shift_next = ld;
          end else if (act_fall) begin
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (!act_s && pclk_rise) begin
            shift_next = {1'b0, shift_reg[FRAME_BITS-1:1]};
            idx_next   = bit_index + IDX_W'(1);
            if (idx_next == IDX_W'(FRAME_BITS)) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Scoreboard bench for snes_pad_emulator acting as a host driving latch and shift clocks.
module tb_snes_pad_emulator;

  localparam int unsigned NB   = 12;
  localparam int unsigned FB   = 16;
  localparam int unsigned HOLD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] buttons;
  logic          cont_activate;
  logic          cont_clk;
  logic          cont_data;
  logic          frame_done;
  logic          frame_aborted;
  logic [4:0]    bit_index;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic exp_q[$];

  snes_pad_emulator #(.NUM_BUTTONS(NB), .FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .cont_activate(cont_activate), .cont_clk(cont_clk),
    .cont_data(cont_data), .frame_done(frame_done),
    .frame_aborted(frame_aborted), .bit_index(bit_index)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)    done_cnt++;
    if (frame_aborted) abort_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame: active-low buttons, then released padding.
  task automatic push_frame(input logic [NB-1:0] b);
    for (int k = 0; k < FB; k++) exp_q.push_back((k < NB) ? ~b[k] : 1'b1);
  endtask

  task automatic latch();
    push_frame(buttons);
    cont_activate = 1'b1; tick(HOLD);
    cont_activate = 1'b0; tick(HOLD);
  endtask

  // Samples the line before issuing one full cont_clk period.
  task automatic shift_bit(output logic b, output logic [4:0] idx);
    b = cont_data; idx = bit_index;
    cont_clk = 1'b1; tick(HOLD);
    cont_clk = 1'b0; tick(HOLD);
  endtask

  task automatic test_reset();
    reset = 1'b1; buttons = '0; cont_activate = 1'b0; cont_clk = 1'b0;
    tick(3);
    checks++;
    if (cont_data !== 1'b1 || frame_done !== 1'b0 || frame_aborted !== 1'b0 || bit_index !== 5'd0) begin
      errors++;
      $display("FAIL reset: data=%b done=%b abort=%b idx=%0d want 1 0 0 0", cont_data, frame_done, frame_aborted, bit_index);
    end
    reset = 1'b0; tick(3);
  endtask

  task automatic test_single_button();
    logic b, e; logic [4:0] idx; int d0;
    d0 = done_cnt; buttons = 12'h001; latch();
    for (int k = 0; k < FB; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e || idx !== 5'(k)) begin
        errors++; $display("FAIL single bit%0d: data=%b idx=%0d want %b %0d", k, b, idx, e, k);
      end
    end
    checks++;
    if (cont_data !== 1'b0 || bit_index !== 5'd16 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL single end: data=%b idx=%0d dones=%0d want 0 16 1", cont_data, bit_index, done_cnt - d0);
    end
  endtask

  task automatic test_pattern();
    logic b, e; logic [4:0] idx; logic [NB-1:0] got;
    buttons = 12'hA5C; latch(); got = '0;
    for (int k = 0; k < FB; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      if (k < NB) got[k] = ~b;
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL pattern bit%0d: data=%b want %b", k, b, e);
      end
    end
    checks++;
    if (got !== 12'hA5C) begin
      errors++; $display("FAIL pattern word: got %h want a5c", got);
    end
  endtask

  task automatic test_abort();
    logic b, e; logic [4:0] idx; int a0, d0;
    buttons = 12'h3C3; latch();
    for (int k = 0; k < 7; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL abort pre bit%0d: data=%b want %b", k, b, e);
      end
    end
    exp_q.delete();
    a0 = abort_cnt; d0 = done_cnt;
    buttons = 12'hFFF; latch();
    checks++;
    if (abort_cnt - a0 != 1 || bit_index !== 5'd0 || done_cnt != d0) begin
      errors++; $display("FAIL abort pulse: aborts=%0d idx=%0d dones=%0d want 1 0 0", abort_cnt - a0, bit_index, done_cnt - d0);
    end
    for (int k = 0; k < FB; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e || idx !== 5'(k)) begin
        errors++; $display("FAIL abort new bit%0d: data=%b idx=%0d want %b %0d", k, b, idx, e, k);
      end
    end
  endtask

  task automatic test_button_change();
    logic b, e; logic [4:0] idx; int a0;
    buttons = 12'h000; latch();
    for (int k = 0; k < FB; k++) begin
      if (k == 5) buttons = 12'hFFF;
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL change cur bit%0d: data=%b want %b", k, b, e);
      end
    end
    a0 = abort_cnt; latch();
    for (int k = 0; k < FB; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL change next bit%0d: data=%b want %b", k, b, e);
      end
    end
    checks++;
    if (abort_cnt != a0) begin
      errors++; $display("FAIL change abort: aborts=%0d want 0", abort_cnt - a0);
    end
  endtask

  task automatic test_overclock();
    logic b, e; logic [4:0] idx; int d0;
    d0 = done_cnt; buttons = 12'h5A5; latch();
    for (int k = 0; k < 20; k++) begin
      shift_bit(b, idx);
      e = (k < FB) ? exp_q.pop_front() : 1'b0;
      checks++;
      if (b !== e || idx !== ((k < FB) ? 5'(k) : 5'd16)) begin
        errors++; $display("FAIL overclock edge%0d: data=%b idx=%0d want %b", k, b, idx, e);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || cont_data !== 1'b0 || bit_index !== 5'd16) begin
      errors++; $display("FAIL overclock end: dones=%0d data=%b idx=%0d want 1 0 16", done_cnt - d0, cont_data, bit_index);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic b, e; logic [4:0] idx;
    buttons = 12'h0F0; latch();
    for (int k = 0; k < 9; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL midreset pre bit%0d: data=%b want %b", k, b, e);
      end
    end
    exp_q.delete();
    reset = 1'b1; tick(2);
    checks++;
    if (cont_data !== 1'b1 || bit_index !== 5'd0) begin
      errors++; $display("FAIL midreset hold: data=%b idx=%0d want 1 0", cont_data, bit_index);
    end
    reset = 1'b0; tick(HOLD);
    cont_clk = 1'b1; tick(HOLD); cont_clk = 1'b0; tick(HOLD);
    checks++;
    if (cont_data !== 1'b1 || bit_index !== 5'd0) begin
      errors++; $display("FAIL midreset idle: data=%b idx=%0d want 1 0", cont_data, bit_index);
    end
    buttons = 12'h800; latch();
    for (int k = 0; k < FB; k++) begin
      shift_bit(b, idx); e = exp_q.pop_front();
      checks++;
      if (b !== e) begin
        errors++; $display("FAIL midreset new bit%0d: data=%b want %b", k, b, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic b, e; logic [4:0] idx;
    for (int f = 0; f < 2; f++) begin
      buttons = 12'($urandom_range(0, 4095)); latch();
      for (int k = 0; k < FB; k++) begin
        shift_bit(b, idx); e = exp_q.pop_front();
        checks++;
        if (b !== e) begin
          errors++; $display("FAIL b2b f%0d bit%0d: data=%b want %b", f, k, b, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_button();
    test_pattern();
    test_abort();
    test_button_change();
    test_overclock();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
